sdram_arb: RTL and testbench
============================

Name: sdram_arb

Overview:
- Arbitrates the single SDRAM controller port between three requesters: refresh scheduler, ROM download loader, CPU memory port.
- Replaces the ad-hoc priority mux in the board top.
- Issues one command at a time to the fixed-latency controller, waits out the command slot, then returns read data and an acknowledge.
- Sits between the core/loader and the sdram controller, in the clock32 domain.

Parameters:
- CMD_CYCLES, 8: controller slot length in clocks, from command pulse to data-valid/next-command-allowed; legal range 2..15.
- RF_PEND_MAX, 3: saturation value of the pending-refresh counter.

Ports:
- clock  in  1  system clock (clock32)
- reset  in  1  synchronous, active-high
- dl  in  1  download active (level); holds off CPU grants
- dl_wr  in  1  single-cycle loader byte strobe
- dl_a  in  22  loader byte address
- dl_d  in  8  loader byte data
- dl_ovf  out  1  sticky: loader byte dropped
- rf_req  in  1  single-cycle refresh request pulse
- cpu_rd  in  1  CPU read request, level
- cpu_wr  in  1  CPU write request, level
- cpu_a  in  22  CPU address
- cpu_d  in  8  CPU write data
- cpu_q  out  8  CPU read data, held until the next CPU read completes
- cpu_ack  out  1  single-cycle completion pulse
- sdr_rf  out  1  refresh command pulse
- sdr_rd  out  1  read command pulse
- sdr_wr  out  1  write command pulse
- sdr_a  out  24  command address, {2'b00, addr22}
- sdr_d  out  16  write data, {8'h00, byte}
- sdr_q  in  16  controller read data, valid at slot end
- busy  out  1  slot in progress

Behaviour:
- All outputs reset to 0; cpu_q resets to 8'hFF.
- Reset clears the FIFO, refresh counter, re-arm flag and dl_ovf.
- Reset mid-slot aborts the slot immediately: no ack is issued.
- Loader path:
  - dl_wr pushes {dl_a, dl_d} into a 2-entry FIFO.
  - Push while full drops the byte and sets dl_ovf.
  - dl_ovf clears on reset or on a rising edge of dl.
- Refresh path:
  - rf_req increments the pend counter, saturating at RF_PEND_MAX.
  - Grant of a refresh decrements it.
  - rf_req and a refresh grant in the same cycle leave the count unchanged.
- CPU path:
  - Request = (cpu_rd | cpu_wr) & armed & !dl.
  - armed clears on cpu_ack and sets on the first cycle with cpu_rd = cpu_wr = 0.
  - cpu_rd and cpu_wr both high: treated as a write.
  - The requester holds a, d, rd and wr stable until cpu_ack.
- Priority, evaluated only in IDLE: refresh pending > FIFO non-empty > CPU.
- FSM:
  - IDLE: on a winning request, pulse exactly one of sdr_rf/sdr_rd/sdr_wr for 1 cycle, drive sdr_a/sdr_d, latch the owner, load cnt = CMD_CYCLES-1, go to BUSY.
  - Refresh commands drive sdr_a/sdr_d to 0.
  - BUSY: busy = 1, sdr_a/sdr_d held, cnt decrements; at cnt == 0 go to DONE.
  - DONE (1 cycle):
    - CPU owner: cpu_ack = 1; on a read, cpu_q <= sdr_q[7:0].
    - Loader owner: pop the FIFO.
    - Back to IDLE; busy = 0.
  - Command-to-command spacing is CMD_CYCLES+1 clocks minimum.
  - CPU read latency: cpu_ack arrives CMD_CYCLES+1 clocks after the grant cycle.
- FIFO push and pop in the same cycle while full is allowed: no overflow.
- dl falling while the CPU is held: the CPU request is granted on the next IDLE evaluation with no pending refresh or loader data.
- dl rising while a CPU slot is in flight: the slot completes normally.

Optional Feature:
- SDRAM_ARB_WAITCNT_EN
- When defined, adds output cpu_wait (16 bits).
  - Saturating counter of cycles in which a CPU request is presented but not granted.
  - Cleared by reset.
  - Readable for performance tuning.
- When undefined, the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package sdram_arb_pkg holds:
  - owner enum: OWN_RF, OWN_DL, OWN_CPU
  - FSM state enum: ST_IDLE, ST_BUSY, ST_DONE
  - address width constant: 22
- One sub-module, sdram_arb_fifo: 2-entry, 30-bit first-word-fall-through FIFO with push/pop/full/empty.

Test Plan:
- CPU read: cpu_rd = 1, cpu_a = 22'h01_2345, sdr_q = 16'h00A5 at slot end, CMD_CYCLES = 8 -> sdr_rd pulse with sdr_a = 24'h012345; cpu_ack 9 clocks after the grant; cpu_q = 8'hA5; no second sdr_rd while cpu_rd stays high.
- Priority: rf_req, dl_wr and cpu_wr all in the same cycle while IDLE -> order sdr_rf, then sdr_wr (loader data), then sdr_wr (CPU data), each spaced 9 clocks apart.
- Loader overflow: 3 dl_wr strobes on consecutive cycles during a CPU slot -> first two bytes written in order; third dropped; dl_ovf = 1 until the next dl rising edge.
- Download hold: dl = 1 with cpu_rd = 1 -> no sdr_rd and no cpu_ack; after dl falls, the grant follows within 1 clock when idle.
- Refresh saturation: 5 rf_req pulses during one busy slot -> exactly 3 sdr_rf commands follow.
- Reset mid-slot: reset asserted at cnt = 4 -> busy = 0, cpu_ack never pulses, cpu_q = 8'hFF, FIFO empty, dl_ovf = 0.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: slot owners, FSM states, loader FIFO entry.
package sdram_arb_pkg;
  localparam int ADDR_W = 22;
  localparam int FIFO_W = ADDR_W + 8;

  typedef enum logic [1:0] {OWN_RF, OWN_DL, OWN_CPU} owner_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } dlEntry_t;
endpackage

// File: rtl/sdram_arb_fifo.sv
// 2-entry first-word-fall-through FIFO for loader bytes; head visible combinationally.
// Push while full is accepted only when a pop happens in the same cycle.
module sdram_arb_fifo
  import sdram_arb_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  dlEntry_t pushDat,
  input  logic     pop,
  output dlEntry_t popDat,
  output logic     full,
  output logic     empty
);
  dlEntry_t   mem [2];
  logic       wrPtr;
  logic       rdPtr;
  logic [1:0] count;
  logic       doPush;
  logic       doPop;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign popDat = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushDat;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doPush) wrPtr <= !wrPtr;
      if (doPop)  rdPtr <= !rdPtr;
      count <= count + {1'b0, doPush} - {1'b0, doPop};
    end
  end
endmodule

// File: rtl/sdram_arb.sv
// Arbitrates the SDRAM controller port: refresh > loader FIFO > CPU, one fixed-length slot at a time.
// Optional SDRAM_ARB_WAITCNT_EN adds cpu_wait, a saturating count of CPU cycles spent waiting.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int CMD_CYCLES  = 8,
  parameter int RF_PEND_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dl,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_a,
  input  logic [7:0]        dl_d,
  output logic              dl_ovf,
  input  logic              rf_req,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_d,
  output logic [7:0]        cpu_q,
  output logic              cpu_ack,
  output logic              sdr_rf,
  output logic              sdr_rd,
  output logic              sdr_wr,
  output logic [23:0]       sdr_a,
  output logic [15:0]       sdr_d,
  input  logic [15:0]       sdr_q,
  output logic              busy
`ifdef SDRAM_ARB_WAITCNT_EN
  ,output logic [15:0]      cpu_wait
`endif
);
  localparam int               PEND_W   = $clog2(RF_PEND_MAX + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(RF_PEND_MAX);
  localparam logic [3:0]       CNT_LOAD = 4'(CMD_CYCLES - 1);

  state_t            state, stateNext;
  owner_t            owner, winner;
  logic [3:0]        cnt;
  logic [PEND_W-1:0] rfPend;
  logic              armed, cpuReq, cpuReqQ, cpuIsRd, dlPrev;
  logic              grant, rfGrant, cpuDone;
  logic              fifoPop, fifoFull, fifoEmpty, fifoDrop;
  dlEntry_t          fifoHead;
  logic [23:0]       aHold, aCmd;
  logic [15:0]       dHold, dCmd;
  logic [7:0]        unusedSdrQ;

  assign unusedSdrQ = sdr_q[15:8];

  assign cpuReq   = (cpu_rd || cpu_wr) && armed && !dl;
  assign cpuDone  = (state == ST_DONE) && (owner == OWN_CPU);
  assign fifoPop  = (state == ST_DONE) && (owner == OWN_DL);
  assign fifoDrop = dl_wr && fifoFull && !fifoPop;
  assign rfGrant  = grant && (winner == OWN_RF);
  assign busy     = (state == ST_BUSY);
  assign sdr_a    = aCmd;
  assign sdr_d    = dCmd;

  sdram_arb_fifo u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (dl_wr),
    .pushDat ({dl_a, dl_d}),
    .pop     (fifoPop),
    .popDat  (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty)
  );

  always_comb begin
    stateNext = state;
    winner    = OWN_CPU;
    grant     = 1'b0;
    sdr_rf    = 1'b0;
    sdr_rd    = 1'b0;
    sdr_wr    = 1'b0;
    aCmd      = aHold;
    dCmd      = dHold;
    case (state)
      ST_IDLE: begin
        if (rfPend != '0) begin
          winner = OWN_RF;
          grant  = 1'b1;
        end else if (!fifoEmpty) begin
          winner = OWN_DL;
          grant  = 1'b1;
        end else if (cpuReqQ) begin
          winner = OWN_CPU;
          grant  = 1'b1;
        end
        if (reset) grant = 1'b0;
        if (grant) begin
          stateNext = ST_BUSY;
          case (winner)
            OWN_RF: begin
              sdr_rf = 1'b1;
              aCmd   = '0;
              dCmd   = '0;
            end
            OWN_DL: begin
              sdr_wr = 1'b1;
              aCmd   = {2'b00, fifoHead.addr};
              dCmd   = {8'h00, fifoHead.data};
            end
            default: begin
              sdr_wr = cpu_wr;
              sdr_rd = !cpu_wr;
              aCmd   = {2'b00, cpu_a};
              dCmd   = {8'h00, cpu_d};
            end
          endcase
        end
      end
      // Leave BUSY on the edge that takes cnt to zero, so DONE is the data-valid cycle.
      ST_BUSY: if (cnt == 4'd1) stateNext = ST_DONE;
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= OWN_RF;
      cnt     <= 4'd0;
      rfPend  <= '0;
      armed   <= 1'b0;
      cpuReqQ <= 1'b0;
      cpuIsRd <= 1'b0;
      dlPrev  <= 1'b0;
      dl_ovf  <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_q   <= 8'hFF;
      aHold   <= '0;
      dHold   <= '0;
    end else begin
      state   <= stateNext;
      cpu_ack <= cpuDone;
      dlPrev  <= dl;
      if (grant) begin
        owner   <= winner;
        cnt     <= CNT_LOAD;
        aHold   <= aCmd;
        dHold   <= dCmd;
        cpuIsRd <= sdr_rd;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 4'd1;
      end
      if (rf_req && !rfGrant && rfPend != PEND_MAX) rfPend <= rfPend + PEND_W'(1);
      else if (!rf_req && rfGrant)                  rfPend <= rfPend - PEND_W'(1);
      if (cpuDone && cpuIsRd) cpu_q <= sdr_q[7:0];
      if (!cpu_rd && !cpu_wr) armed <= 1'b1;
      else if (cpuDone)       armed <= 1'b0;
      // Registered so a CPU request raised alongside refresh/loader strobes loses to them.
      cpuReqQ <= cpuReq && !cpuDone;
      if (fifoDrop)             dl_ovf <= 1'b1;
      else if (dl && !dlPrev)   dl_ovf <= 1'b0;
    end
  end

`ifdef SDRAM_ARB_WAITCNT_EN
  logic cpuHeld;
  assign cpuHeld = cpuReq && !(grant && winner == OWN_CPU)
                   && !(state != ST_IDLE && owner == OWN_CPU);

  always_ff @(posedge clock) begin
    if (reset)                             cpu_wait <= 16'd0;
    else if (cpuHeld && cpu_wait != 16'hFFFF) cpu_wait <= cpu_wait + 16'd1;
  end
`endif
endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with CMD_CYCLES = 8: command log at negedge, controller read-data model.
module tb_sdram_arb;
  localparam int CMD = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dl = 1'b0, dl_wr = 1'b0, rf_req = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [21:0] dl_a = '0, cpu_a = '0;
  logic [7:0]  dl_d = '0, cpu_d = '0;
  logic        dl_ovf, cpu_ack, sdr_rf, sdr_rd, sdr_wr, busy;
  logic [7:0]  cpu_q;
  logic [23:0] sdr_a;
  logic [15:0] sdr_d;
  logic [15:0] sdr_q = 16'hBEEF;
`ifdef SDRAM_ARB_WAITCNT_EN
  logic [15:0] cpu_wait;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdAt = -1000;
  logic [15:0] rdData = 16'h00A5;

  int          cmdCyc[$];
  logic [2:0]  cmdKind[$];
  logic [23:0] cmdA[$];
  logic [15:0] cmdD[$];
  int          ackCyc[$];

  sdram_arb #(.CMD_CYCLES(CMD), .RF_PEND_MAX(3)) dut (
    .clock(clock), .reset(reset), .dl(dl), .dl_wr(dl_wr), .dl_a(dl_a), .dl_d(dl_d),
    .dl_ovf(dl_ovf), .rf_req(rf_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a),
    .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack), .sdr_rf(sdr_rf), .sdr_rd(sdr_rd),
    .sdr_wr(sdr_wr), .sdr_a(sdr_a), .sdr_d(sdr_d), .sdr_q(sdr_q), .busy(busy)
`ifdef SDRAM_ARB_WAITCNT_EN
    , .cpu_wait(cpu_wait)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Log every command/ack; the controller model returns rdData only in the slot-end cycle.
  always @(negedge clock) begin
    if (sdr_rf || sdr_rd || sdr_wr) begin
      cmdCyc.push_back(cyc);
      cmdKind.push_back({sdr_rf, sdr_rd, sdr_wr});
      cmdA.push_back(sdr_a);
      cmdD.push_back(sdr_d);
      if (sdr_rd) rdAt = cyc;
    end
    if (cpu_ack) ackCyc.push_back(cyc);
    sdr_q = (cyc == rdAt + CMD) ? rdData : 16'hBEEF;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_logs();
    cmdCyc.delete(); cmdKind.delete(); cmdA.delete(); cmdD.delete(); ackCyc.delete();
    rdAt = -1000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    checks++; if ({busy, cpu_ack, sdr_rf, sdr_rd, sdr_wr, dl_ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 000000", {busy, cpu_ack, sdr_rf, sdr_rd, sdr_wr, dl_ovf}); end
    checks++; if (sdr_a !== 24'h0) begin errors++; $display("FAIL reset_sdr_a: got %h want 000000", sdr_a); end
    checks++; if (sdr_d !== 16'h0) begin errors++; $display("FAIL reset_sdr_d: got %h want 0000", sdr_d); end
    checks++; if (cpu_q !== 8'hFF) begin errors++; $display("FAIL reset_cpu_q: got %h want ff", cpu_q); end
    reset = 1'b0;
    step(2);
    clear_logs();
  endtask

  task automatic test_cpu_read();
    int k;
    do_reset();
    rdData = 16'h00A5;
    k = cyc;
    cpu_a = 22'h012345; cpu_rd = 1'b1;
    step(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_start: got %b want 1", busy); end
    step(6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_last: got %b want 1", busy); end
    step(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_done: got %b want 0", busy); end
    step(31);
    checks++; if (cmdCyc.size() !== 1) begin errors++; $display("FAIL rd_cmd_count: got %0d want 1", cmdCyc.size()); end
    if (cmdCyc.size() >= 1) begin
      checks++; if (cmdCyc[0] !== k + 1) begin errors++; $display("FAIL rd_grant_cycle: got %0d want %0d", cmdCyc[0], k + 1); end
      checks++; if ({cmdKind[0], cmdA[0]} !== {3'b010, 24'h012345}) begin
        errors++; $display("FAIL rd_cmd: got kind %b a %h want kind 010 a 012345", cmdKind[0], cmdA[0]); end
    end
    checks++; if (ackCyc.size() !== 1) begin errors++; $display("FAIL rd_ack_count: got %0d want 1", ackCyc.size()); end
    if (ackCyc.size() >= 1) begin
      checks++; if (ackCyc[0] !== k + 1 + CMD + 1) begin
        errors++; $display("FAIL rd_ack_latency: got %0d want %0d", ackCyc[0], k + 1 + CMD + 1); end
    end
    checks++; if (cpu_q !== 8'hA5) begin errors++; $display("FAIL rd_cpu_q: got %h want a5", cpu_q); end
    cpu_rd = 1'b0;
    step(2);
  endtask

  task automatic test_priority();
    int k;
    int          eCyc[3];
    logic [42:0] eCmd[3];
    do_reset();
    k = cyc;
    rf_req = 1'b1; dl_wr = 1'b1; dl_a = 22'h000010; dl_d = 8'h5A;
    cpu_wr = 1'b1; cpu_a = 22'h3F0001; cpu_d = 8'hC3;
    step(1);
    rf_req = 1'b0; dl_wr = 1'b0;
    step(35);
    cpu_wr = 1'b0;
    eCyc[0] = k + 1;  eCmd[0] = {3'b100, 24'h000000, 16'h0000};
    eCyc[1] = k + 10; eCmd[1] = {3'b001, 24'h000010, 16'h005A};
    eCyc[2] = k + 19; eCmd[2] = {3'b001, 24'h3F0001, 16'h00C3};
    checks++; if (cmdCyc.size() !== 3) begin errors++; $display("FAIL pri_cmd_count: got %0d want 3", cmdCyc.size()); end
    for (int i = 0; i < 3 && i < cmdCyc.size(); i++) begin
      checks++; if (cmdCyc[i] !== eCyc[i]) begin errors++; $display("FAIL pri_cycle%0d: got %0d want %0d", i, cmdCyc[i], eCyc[i]); end
      checks++; if ({cmdKind[i], cmdA[i], cmdD[i]} !== eCmd[i]) begin
        errors++; $display("FAIL pri_cmd%0d: got %h want %h", i, {cmdKind[i], cmdA[i], cmdD[i]}, eCmd[i]); end
    end
    checks++; if (ackCyc.size() !== 1) begin errors++; $display("FAIL pri_ack_count: got %0d want 1", ackCyc.size()); end
    if (ackCyc.size() >= 1) begin
      checks++; if (ackCyc[0] !== k + 28) begin errors++; $display("FAIL pri_ack_cycle: got %0d want %0d", ackCyc[0], k + 28); end
    end
    step(2);
  endtask

  task automatic test_overflow();
    do_reset();
    cpu_wr = 1'b1; cpu_a = 22'h000100; cpu_d = 8'h11;
    step(2);
    dl_wr = 1'b1; dl_a = 22'h000A00; dl_d = 8'hA0;
    step(1);
    dl_a = 22'h000A01; dl_d = 8'hA1;
    step(1);
    dl_a = 22'h000A02; dl_d = 8'hA2;
    step(1);
    dl_wr = 1'b0;
    checks++; if (dl_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", dl_ovf); end
    step(40);
    cpu_wr = 1'b0;
    checks++; if (cmdCyc.size() !== 3) begin errors++; $display("FAIL ovf_cmd_count: got %0d want 3", cmdCyc.size()); end
    if (cmdCyc.size() >= 3) begin
      checks++; if ({cmdKind[1], cmdA[1], cmdD[1]} !== {3'b001, 24'h000A00, 16'h00A0}) begin
        errors++; $display("FAIL ovf_byte0: got %h want 1000a0000a0", {cmdKind[1], cmdA[1], cmdD[1]}); end
      checks++; if ({cmdKind[2], cmdA[2], cmdD[2]} !== {3'b001, 24'h000A01, 16'h00A1}) begin
        errors++; $display("FAIL ovf_byte1: got %h want 1000a0100a1", {cmdKind[2], cmdA[2], cmdD[2]}); end
    end
    checks++; if (dl_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", dl_ovf); end
    dl = 1'b1;
    step(1);
    checks++; if (dl_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_dl_rise: got %b want 0", dl_ovf); end
    dl = 1'b0;
    step(2);
  endtask

  task automatic test_push_pop_full();
    int k;
    int          eCyc[4];
    logic [39:0] eCmd[4];
    do_reset();
    k = cyc;
    cpu_wr = 1'b1; cpu_a = 22'h000200; cpu_d = 8'h22;
    step(2);
    dl_wr = 1'b1; dl_a = 22'h000B00; dl_d = 8'hB0;
    step(1);
    dl_a = 22'h000B01; dl_d = 8'hB1;
    step(1);
    dl_wr = 1'b0;
    step(14);
    dl_wr = 1'b1; dl_a = 22'h000B02; dl_d = 8'hB2;
    step(1);
    dl_wr = 1'b0;
    step(30);
    cpu_wr = 1'b0;
    eCyc[0] = k + 1;  eCmd[0] = {24'h000200, 16'h0022};
    eCyc[1] = k + 10; eCmd[1] = {24'h000B00, 16'h00B0};
    eCyc[2] = k + 19; eCmd[2] = {24'h000B01, 16'h00B1};
    eCyc[3] = k + 28; eCmd[3] = {24'h000B02, 16'h00B2};
    checks++; if (dl_ovf !== 1'b0) begin errors++; $display("FAIL pp_no_ovf: got %b want 0", dl_ovf); end
    checks++; if (cmdCyc.size() !== 4) begin errors++; $display("FAIL pp_cmd_count: got %0d want 4", cmdCyc.size()); end
    for (int i = 0; i < 4 && i < cmdCyc.size(); i++) begin
      checks++; if ({cmdCyc[i], cmdA[i], cmdD[i]} !== {eCyc[i], eCmd[i]}) begin
        errors++; $display("FAIL pp_cmd%0d: got cyc %0d a %h d %h want cyc %0d a/d %h", i, cmdCyc[i], cmdA[i], cmdD[i], eCyc[i], eCmd[i]); end
    end
    step(2);
  endtask

  task automatic test_refresh_sat();
    int k;
    int nRf;
    do_reset();
    k = cyc;
    cpu_rd = 1'b1; cpu_a = 22'h000300;
    step(2);
    rf_req = 1'b1;
    step(5);
    rf_req = 1'b0;
    step(50);
    cpu_rd = 1'b0;
    nRf = 0;
    foreach (cmdKind[i]) if (cmdKind[i] == 3'b100) nRf++;
    checks++; if (nRf !== 3) begin errors++; $display("FAIL rf_sat_count: got %0d want 3", nRf); end
    checks++; if (cmdCyc.size() !== 4) begin errors++; $display("FAIL rf_cmd_count: got %0d want 4", cmdCyc.size()); end
    for (int i = 1; i < 4 && i < cmdCyc.size(); i++) begin
      checks++; if (cmdCyc[i] !== k + 1 + 9 * i) begin
        errors++; $display("FAIL rf_cycle%0d: got %0d want %0d", i, cmdCyc[i], k + 1 + 9 * i); end
    end
    step(2);
  endtask

  task automatic test_dl_hold();
    int k;
    do_reset();
    rdData = 16'h1E3C;
    dl = 1'b1; cpu_rd = 1'b1; cpu_a = 22'h000400;
    step(20);
    checks++; if (cmdCyc.size() + ackCyc.size() !== 0) begin
      errors++; $display("FAIL hold_no_grant: got %0d cmds %0d acks want 0", cmdCyc.size(), ackCyc.size()); end
    k = cyc;
    dl = 1'b0;
    step(3);
    dl = 1'b1;
    step(15);
    checks++; if (cmdCyc.size() !== 1) begin errors++; $display("FAIL hold_cmd_count: got %0d want 1", cmdCyc.size()); end
    if (cmdCyc.size() >= 1) begin
      checks++; if (cmdCyc[0] !== k + 1) begin errors++; $display("FAIL hold_release: got %0d want %0d", cmdCyc[0], k + 1); end
    end
    checks++; if (ackCyc.size() !== 1) begin errors++; $display("FAIL hold_ack_count: got %0d want 1", ackCyc.size()); end
    if (ackCyc.size() >= 1) begin
      checks++; if (ackCyc[0] !== k + 10) begin errors++; $display("FAIL hold_ack_cycle: got %0d want %0d", ackCyc[0], k + 10); end
    end
    checks++; if (cpu_q !== 8'h3C) begin errors++; $display("FAIL hold_cpu_q: got %h want 3c", cpu_q); end
    cpu_rd = 1'b0; dl = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    rdData = 16'h0077;
    cpu_rd = 1'b1; cpu_a = 22'h000500;
    step(2);
    dl_wr = 1'b1; dl_a = 22'h000C00; dl_d = 8'hC0;
    step(1);
    dl_a = 22'h000C01;
    step(1);
    dl_a = 22'h000C02; rf_req = 1'b1;
    step(1);
    dl_wr = 1'b0; rf_req = 1'b0;
    checks++; if (dl_ovf !== 1'b1) begin errors++; $display("FAIL rst_pre_ovf: got %b want 1", dl_ovf); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (dl_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", dl_ovf); end
    checks++; if (cpu_q !== 8'hFF) begin errors++; $display("FAIL rst_cpu_q: got %h want ff", cpu_q); end
    step(30);
    checks++; if (ackCyc.size() !== 0) begin errors++; $display("FAIL rst_no_ack: got %0d want 0", ackCyc.size()); end
    checks++; if (cmdCyc.size() !== 1) begin errors++; $display("FAIL rst_no_cmds: got %0d want 1", cmdCyc.size()); end
    cpu_rd = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_overflow();
    test_push_pop_full();
    test_refresh_sat();
    test_dl_hold();
    test_reset_mid_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
